// File: rtl/src_ctrl_pkg.sv
// SRC control unit shared definitions: opcodes, FSM states,
// instruction classes and the strobe bundle decoded from state.
package src_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RESET_S = 4'd0,
        T0      = 4'd1,
        T1      = 4'd2,
        T2      = 4'd3,
        T3      = 4'd4,
        T4      = 4'd5,
        T5      = 4'd6,
        T6      = 4'd7,
        T7      = 4'd8,
        HALT_S  = 4'd9
    } state_t;

    localparam int NCLS      = 16;
    localparam int CL_LOAD   = 0;
    localparam int CL_LDI    = 1;
    localparam int CL_STORE  = 2;
    localparam int CL_ALU3   = 3;
    localparam int CL_ALUI   = 4;
    localparam int CL_UNARY  = 5;
    localparam int CL_MULDIV = 6;
    localparam int CL_BR     = 7;
    localparam int CL_JR     = 8;
    localparam int CL_JAL    = 9;
    localparam int CL_IN     = 10;
    localparam int CL_OUT    = 11;
    localparam int CL_MFHI   = 12;
    localparam int CL_MFLO   = 13;
    localparam int CL_NOP    = 14;
    localparam int CL_HALT   = 15;

    typedef logic [NCLS-1:0] op_class_t;

    typedef struct packed {
        logic       hi_in;
        logic       lo_in;
        logic       pc_in;
        logic       mdr_in;
        logic       z_in;
        logic       y_in;
        logic       mar_in;
        logic       ir_in;
        logic       con_in;
        logic       outport_in;
        logic       hi_out;
        logic       lo_out;
        logic       zhi_out;
        logic       zlo_out;
        logic       pc_out;
        logic       mdr_out;
        logic       inport_out;
        logic       c_out;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       read;
        logic       write;
        logic       inc_pc;
        logic [4:0] alu_op;
    } ctrl_t;

    function automatic logic [4:0] alui_op(input logic [4:0] op);
        case (op)
            OP_ANDI: return OP_AND;
            OP_ORI:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/src_control_unit_if.sv
// Control-unit <-> datapath strobe bundle. MEM_WAIT_EN adds the
// MemReady handshake from memory.
interface src_control_unit_if;

    logic        Stop;
    logic [31:0] IR;
    logic        CON;
`ifdef MEM_WAIT_EN
    logic        MemReady;
`endif
    logic        Run;
    logic [4:0]  AluOp;
    logic HIin, LOin, PCin, MDRin, Zin, Yin;
    logic MARin, IRin, CONin, OUTPORTin;
    logic HIout, LOout, ZHIout, ZLOout, PCout;
    logic MDRout, INPORTout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic Read, write, IncPC;

    modport master (
        input  Stop, IR, CON,
`ifdef MEM_WAIT_EN
        input  MemReady,
`endif
        output Run, AluOp,
        output HIin, LOin, PCin, MDRin, Zin, Yin,
        output MARin, IRin, CONin, OUTPORTin,
        output HIout, LOout, ZHIout, ZLOout, PCout,
        output MDRout, INPORTout, Cout,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output Read, write, IncPC
    );

    modport slave (
        output Stop, IR, CON,
`ifdef MEM_WAIT_EN
        output MemReady,
`endif
        input  Run, AluOp,
        input  HIin, LOin, PCin, MDRin, Zin, Yin,
        input  MARin, IRin, CONin, OUTPORTin,
        input  HIout, LOout, ZHIout, ZLOout, PCout,
        input  MDRout, INPORTout, Cout,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  Read, write, IncPC
    );

endinterface

// File: rtl/src_control_unit_op_class_decode.sv
// Opcode to one-hot instruction class; undefined opcodes fold into NOP.
module op_class_decode
    import src_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        unique case (opcode)
            OP_LD:   cls[CL_LOAD]  = 1'b1;
            OP_LDI:  cls[CL_LDI]   = 1'b1;
            OP_ST:   cls[CL_STORE] = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                     cls[CL_ALU3]  = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:
                     cls[CL_ALUI]  = 1'b1;
            OP_NEG, OP_NOT:
                     cls[CL_UNARY] = 1'b1;
            OP_MUL, OP_DIV:
                     cls[CL_MULDIV] = 1'b1;
            OP_BR:   cls[CL_BR]    = 1'b1;
            OP_JR:   cls[CL_JR]    = 1'b1;
            OP_JAL:  cls[CL_JAL]   = 1'b1;
            OP_IN:   cls[CL_IN]    = 1'b1;
            OP_OUT:  cls[CL_OUT]   = 1'b1;
            OP_MFHI: cls[CL_MFHI]  = 1'b1;
            OP_MFLO: cls[CL_MFLO]  = 1'b1;
            OP_HALT: cls[CL_HALT]  = 1'b1;
            default: cls[CL_NOP]   = 1'b1;
        endcase
    end

endmodule

// File: rtl/src_control_unit.sv
// Hardwired SRC control FSM: fetch T0-T2, execute T3-T7, Moore strobes.
// MEM_WAIT_EN: memory states stretch until MemReady is sampled high.
module src_control_unit
    import src_ctrl_pkg::*;
#(
    parameter int RESET_HOLD = 1
) (
    input  logic Clock,
    input  logic Reset,
    src_control_unit_if.master ctl
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

    state_t     state, state_nxt;
    logic [3:0] hold_cnt;
    op_class_t  cls;
    ctrl_t      c;
    logic [4:0] op;
    logic       last, mem, mem_ok;
    logic       unused_ir;

    assign op        = ctl.IR[31:27];
    assign unused_ir = ^ctl.IR[26:0];

`ifdef MEM_WAIT_EN
    assign mem_ok = ctl.MemReady;
`else
    assign mem_ok = 1'b1;
`endif

    op_class_decode u_dec (
        .opcode (op),
        .cls    (cls)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= RESET_S;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= (state == RESET_S) ? hold_cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        c         = '0;
        last      = 1'b0;
        mem       = 1'b0;
        unique case (state)
            RESET_S: if (hold_cnt == HOLD_LAST) state_nxt = T0;
            // IncPC turns the ALU add into PC+1
            T0: begin
                c.pc_out = 1'b1; c.mar_in = 1'b1;
                c.inc_pc = 1'b1; c.z_in   = 1'b1;
                c.alu_op = OP_ADD;
                state_nxt = T1;
            end
            T1: begin
                c.zlo_out = 1'b1; c.pc_in  = 1'b1;
                c.read    = 1'b1; c.mdr_in = 1'b1;
                mem       = 1'b1;
                state_nxt = T2;
            end
            T2: begin
                c.mdr_out = 1'b1; c.ir_in = 1'b1;
                if (cls[CL_NOP]) last = 1'b1;
                else             state_nxt = T3;
            end
            T3: begin
                state_nxt = T4;
                unique case (1'b1)
                    cls[CL_LOAD], cls[CL_LDI], cls[CL_STORE]: begin
                        c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
                    end
                    cls[CL_ALU3], cls[CL_ALUI]: begin
                        c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
                    end
                    cls[CL_UNARY]: begin
                        c.grb = 1'b1; c.r_out = 1'b1;
                        c.z_in = 1'b1; c.alu_op = op;
                    end
                    cls[CL_MULDIV]: begin
                        c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
                    end
                    cls[CL_BR]: begin
                        c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1;
                    end
                    cls[CL_JR]: begin
                        c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1;
                        last = 1'b1;
                    end
                    cls[CL_JAL]: begin
                        c.pc_out = 1'b1; c.grb = 1'b1; c.r_in = 1'b1;
                    end
                    cls[CL_IN]: begin
                        c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                        last = 1'b1;
                    end
                    cls[CL_OUT]: begin
                        c.gra = 1'b1; c.r_out = 1'b1; c.outport_in = 1'b1;
                        last = 1'b1;
                    end
                    cls[CL_MFHI]: begin
                        c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                        last = 1'b1;
                    end
                    cls[CL_MFLO]: begin
                        c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                        last = 1'b1;
                    end
                    cls[CL_HALT]: state_nxt = HALT_S;
                    default:      state_nxt = T0;
                endcase
            end
            T4: begin
                state_nxt = T5;
                unique case (1'b1)
                    cls[CL_LOAD], cls[CL_LDI], cls[CL_STORE]: begin
                        c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = OP_ADD;
                    end
                    cls[CL_ALU3]: begin
                        c.grc = 1'b1; c.r_out = 1'b1;
                        c.z_in = 1'b1; c.alu_op = op;
                    end
                    cls[CL_ALUI]: begin
                        c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = alui_op(op);
                    end
                    cls[CL_UNARY]: begin
                        c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                        last = 1'b1;
                    end
                    cls[CL_MULDIV]: begin
                        c.grb = 1'b1; c.r_out = 1'b1;
                        c.z_in = 1'b1; c.alu_op = op;
                    end
                    cls[CL_BR]: begin
                        c.pc_out = 1'b1; c.y_in = 1'b1;
                    end
                    cls[CL_JAL]: begin
                        c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1;
                        last = 1'b1;
                    end
                    default: state_nxt = T0;
                endcase
            end
            T5: begin
                state_nxt = T6;
                unique case (1'b1)
                    cls[CL_LOAD], cls[CL_STORE]: begin
                        c.zlo_out = 1'b1; c.mar_in = 1'b1;
                    end
                    cls[CL_LDI], cls[CL_ALU3], cls[CL_ALUI]: begin
                        c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                        last = 1'b1;
                    end
                    cls[CL_MULDIV]: begin
                        c.zlo_out = 1'b1; c.lo_in = 1'b1;
                    end
                    cls[CL_BR]: begin
                        c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = OP_ADD;
                    end
                    default: state_nxt = T0;
                endcase
            end
            T6: begin
                state_nxt = T7;
                unique case (1'b1)
                    cls[CL_LOAD]: begin
                        c.read = 1'b1; c.mdr_in = 1'b1; mem = 1'b1;
                    end
                    cls[CL_STORE]: begin
                        c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
                    end
                    cls[CL_MULDIV]: begin
                        c.zhi_out = 1'b1; c.hi_in = 1'b1; last = 1'b1;
                    end
                    // untaken branch still spends this cycle
                    cls[CL_BR]: begin
                        c.zlo_out = 1'b1; c.pc_in = ctl.CON; last = 1'b1;
                    end
                    default: state_nxt = T0;
                endcase
            end
            T7: begin
                last = 1'b1;
                unique case (1'b1)
                    cls[CL_LOAD]: begin
                        c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                    end
                    cls[CL_STORE]: begin
                        c.write = 1'b1; mem = 1'b1;
                    end
                    default: ;
                endcase
            end
            HALT_S:  state_nxt = HALT_S;
            default: state_nxt = RESET_S;
        endcase
        if (last)           state_nxt = ctl.Stop ? HALT_S : T0;
        if (mem && !mem_ok) state_nxt = state;
    end

    assign ctl.Run       = (state != RESET_S) && (state != HALT_S);
    assign ctl.AluOp     = c.alu_op;
    assign ctl.HIin      = c.hi_in;
    assign ctl.LOin      = c.lo_in;
    assign ctl.PCin      = c.pc_in;
    assign ctl.MDRin     = c.mdr_in;
    assign ctl.Zin       = c.z_in;
    assign ctl.Yin       = c.y_in;
    assign ctl.MARin     = c.mar_in;
    assign ctl.IRin      = c.ir_in;
    assign ctl.CONin     = c.con_in;
    assign ctl.OUTPORTin = c.outport_in;
    assign ctl.HIout     = c.hi_out;
    assign ctl.LOout     = c.lo_out;
    assign ctl.ZHIout    = c.zhi_out;
    assign ctl.ZLOout    = c.zlo_out;
    assign ctl.PCout     = c.pc_out;
    assign ctl.MDRout    = c.mdr_out;
    assign ctl.INPORTout = c.inport_out;
    assign ctl.Cout      = c.c_out;
    assign ctl.Gra       = c.gra;
    assign ctl.Grb       = c.grb;
    assign ctl.Grc       = c.grc;
    assign ctl.Rin       = c.r_in;
    assign ctl.Rout      = c.r_out;
    assign ctl.BAout     = c.ba_out;
    assign ctl.Read      = c.read;
    assign ctl.write     = c.write;
    assign ctl.IncPC     = c.inc_pc;

endmodule

// File: tb/tb_src_control_unit.sv
// Bench for src_control_unit: per-instruction strobe model plus literal
// spot checks. MEM_WAIT_EN enables the fetch wait-state scenario.
module tb_src_control_unit;

    typedef logic [26:0] mask_t;
    typedef logic [32:0] vec_t;

    localparam mask_t HIIN      = mask_t'(1) << 0;
    localparam mask_t LOIN      = mask_t'(1) << 1;
    localparam mask_t PCIN      = mask_t'(1) << 2;
    localparam mask_t MDRIN     = mask_t'(1) << 3;
    localparam mask_t ZIN       = mask_t'(1) << 4;
    localparam mask_t YIN       = mask_t'(1) << 5;
    localparam mask_t MARIN     = mask_t'(1) << 6;
    localparam mask_t IRIN      = mask_t'(1) << 7;
    localparam mask_t CONIN     = mask_t'(1) << 8;
    localparam mask_t OUTPORTIN = mask_t'(1) << 9;
    localparam mask_t HIOUT     = mask_t'(1) << 10;
    localparam mask_t LOOUT     = mask_t'(1) << 11;
    localparam mask_t ZHIOUT    = mask_t'(1) << 12;
    localparam mask_t ZLOOUT    = mask_t'(1) << 13;
    localparam mask_t PCOUT     = mask_t'(1) << 14;
    localparam mask_t MDROUT    = mask_t'(1) << 15;
    localparam mask_t INPORTOUT = mask_t'(1) << 16;
    localparam mask_t COUT      = mask_t'(1) << 17;
    localparam mask_t GRA       = mask_t'(1) << 18;
    localparam mask_t GRB       = mask_t'(1) << 19;
    localparam mask_t GRC       = mask_t'(1) << 20;
    localparam mask_t RIN       = mask_t'(1) << 21;
    localparam mask_t ROUT      = mask_t'(1) << 22;
    localparam mask_t BAOUT     = mask_t'(1) << 23;
    localparam mask_t READ      = mask_t'(1) << 24;
    localparam mask_t WRITE     = mask_t'(1) << 25;
    localparam mask_t INCPC     = mask_t'(1) << 26;

    localparam logic [4:0] NA   = 5'd0;
    localparam logic [4:0] ADD  = 5'b00011;
    localparam logic [4:0] ANDO = 5'b00101;
    localparam logic [4:0] ORO  = 5'b00110;
    localparam vec_t       IDLE = '0;
    localparam int         HOLD = 1;

    logic  Clock = 1'b0;
    logic  Reset;
    int    checks = 0;
    int    errors = 0;
    vec_t  q[$];
    vec_t  seq[$];
    vec_t  hist[$];
    string tag = "init";
`ifdef MEM_WAIT_EN
    int    t1_wait = 0;
`endif

    src_control_unit_if ifc ();

    src_control_unit #(.RESET_HOLD(HOLD)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .ctl   (ifc.master)
    );

    always #5 Clock = ~Clock;

    function automatic vec_t dut_vec();
        return {ifc.IncPC, ifc.write, ifc.Read, ifc.BAout, ifc.Rout,
                ifc.Rin, ifc.Grc, ifc.Grb, ifc.Gra, ifc.Cout,
                ifc.INPORTout, ifc.MDRout, ifc.PCout, ifc.ZLOout,
                ifc.ZHIout, ifc.LOout, ifc.HIout, ifc.OUTPORTin,
                ifc.CONin, ifc.IRin, ifc.MARin, ifc.Yin, ifc.Zin,
                ifc.MDRin, ifc.PCin, ifc.LOin, ifc.HIin,
                ifc.AluOp, ifc.Run};
    endfunction

    // one comparison per cycle while the model has an expectation queued
    always @(negedge Clock) begin
        if (q.size() > 0) begin
            vec_t e;
            vec_t a;
            int   nbus;
            e = q.pop_front();
            a = dut_vec();
            hist.push_back(a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s cyc%0d: got %h required %h",
                         tag, hist.size() - 1, a, e);
            end
            nbus = $countones({a[23:16], a[28], a[29]});
            checks++;
            if ((a[30] && a[31]) || nbus > 1) begin
                errors++;
                $display("FAIL %s cyc%0d exclusivity: rd=%0b wr=%0b drivers=%0d required <=1",
                         tag, hist.size() - 1, a[30], a[31], nbus);
            end
        end
    end

    function automatic logic has(input int cyc, input mask_t m);
        vec_t v;
        v = hist[cyc];
        return (v[32:6] & m) == m;
    endfunction

    function automatic logic [4:0] alu_at(input int cyc);
        vec_t v;
        v = hist[cyc];
        return v[5:1];
    endfunction

    function automatic logic run_at(input int cyc);
        vec_t v;
        v = hist[cyc];
        return v[0];
    endfunction

    task automatic lit(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic add(input mask_t m, input logic [4:0] alu);
        seq.push_back({m, alu, 1'b1});
    endtask

    // expected strobe sequence of one whole instruction, fetch included
    task automatic build_seq(input logic [4:0] op, input logic con);
        seq.delete();
        add(PCOUT | MARIN | INCPC | ZIN, ADD);
        add(ZLOOUT | PCIN | READ | MDRIN, NA);
        add(MDROUT | IRIN, NA);
        if (op <= 5'd2) begin
            add(GRB | BAOUT | YIN, NA);
            add(COUT | ZIN, ADD);
            if (op == 5'd1) begin
                add(ZLOOUT | GRA | RIN, NA);
            end else if (op == 5'd0) begin
                add(ZLOOUT | MARIN, NA);
                add(READ | MDRIN, NA);
                add(MDROUT | GRA | RIN, NA);
            end else begin
                add(ZLOOUT | MARIN, NA);
                add(GRA | ROUT | MDRIN, NA);
                add(WRITE, NA);
            end
        end else if (op <= 5'd11) begin
            add(GRB | ROUT | YIN, NA);
            add(GRC | ROUT | ZIN, op);
            add(ZLOOUT | GRA | RIN, NA);
        end else if (op <= 5'd14) begin
            add(GRB | ROUT | YIN, NA);
            add(COUT | ZIN, op == 5'd12 ? ADD : (op == 5'd13 ? ANDO : ORO));
            add(ZLOOUT | GRA | RIN, NA);
        end else if (op <= 5'd16) begin
            add(GRA | ROUT | YIN, NA);
            add(GRB | ROUT | ZIN, op);
            add(ZLOOUT | LOIN, NA);
            add(ZHIOUT | HIIN, NA);
        end else if (op <= 5'd18) begin
            add(GRB | ROUT | ZIN, op);
            add(ZLOOUT | GRA | RIN, NA);
        end else if (op == 5'd19) begin
            add(GRA | ROUT | CONIN, NA);
            add(PCOUT | YIN, NA);
            add(COUT | ZIN, ADD);
            add(ZLOOUT | (con ? PCIN : mask_t'(0)), NA);
        end else if (op == 5'd20) begin
            add(GRA | ROUT | PCIN, NA);
        end else if (op == 5'd21) begin
            add(PCOUT | GRB | RIN, NA);
            add(GRA | ROUT | PCIN, NA);
        end else if (op == 5'd22) begin
            add(INPORTOUT | GRA | RIN, NA);
        end else if (op == 5'd23) begin
            add(GRA | ROUT | OUTPORTIN, NA);
        end else if (op == 5'd24) begin
            add(HIOUT | GRA | RIN, NA);
        end else if (op == 5'd25) begin
            add(LOOUT | GRA | RIN, NA);
        end else if (op == 5'd27) begin
            add(mask_t'(0), NA);
        end
    endtask

    task automatic apply_reset(input int n);
        Reset    = 1'b1;
        ifc.Stop = 1'b0;
        @(posedge Clock); #1;
        tag = "reset";
        for (int i = 1; i < n; i++) begin
            q.push_back(IDLE);
            @(posedge Clock); #1;
        end
        Reset = 1'b0;
        repeat (HOLD) begin
            q.push_back(IDLE);
            @(posedge Clock); #1;
        end
    endtask

    task automatic expect_idle(input int n);
        repeat (n) begin
            q.push_back(IDLE);
            @(posedge Clock); #1;
        end
    endtask

    // called just after the edge that enters T0; abort_at >= 0 asserts
    // Reset during that step of the instruction
    task automatic run_instr(input string name, input logic [31:0] ir,
                             input logic con, input logic stop,
                             input int abort_at);
        tag      = name;
        ifc.IR   = ir;
        ifc.CON  = con;
        ifc.Stop = stop;
        build_seq(ir[31:27], con);
        for (int i = 0; i < seq.size(); i++) begin
`ifdef MEM_WAIT_EN
            if (i == 1) begin
                ifc.MemReady = 1'b0;
                repeat (t1_wait) begin
                    q.push_back(seq[1]);
                    @(posedge Clock); #1;
                end
                ifc.MemReady = 1'b1;
            end
`endif
            q.push_back(seq[i]);
            if (i == abort_at) begin
                apply_reset(3);
                return;
            end
            @(posedge Clock); #1;
        end
    endtask

    initial begin
        int b;
        int b2;
        Reset    = 1'b1;
        ifc.IR   = '0;
        ifc.CON  = 1'b0;
        ifc.Stop = 1'b0;
`ifdef MEM_WAIT_EN
        ifc.MemReady = 1'b1;
`endif
        b = hist.size();
        apply_reset(3);
        lit("rst_run", 32'(run_at(b)), 0);
        lit("rst_strobes", 32'(hist[b + 1] >> 1), 0);

        b = hist.size();
        run_instr("ld", 32'h00800075, 1'b0, 1'b0, -1);
        lit("first_T0", 32'(has(b, PCOUT | MARIN | INCPC | ZIN)), 1);
        lit("ld_T3_alu", 32'(alu_at(b + 3)), 0);
        lit("ld_T4_alu", 32'(alu_at(b + 4)), 32'h03);
        lit("ld_T7", 32'(has(b + 7, MDROUT | GRA | RIN)), 1);

        b = hist.size();
        run_instr("add", 32'h1A9B8000, 1'b0, 1'b0, -1);
        b2 = hist.size();
        run_instr("st", 32'h1328001F, 1'b0, 1'b0, -1);
        lit("ld_back_T0", 32'(has(b, PCOUT | MARIN)), 1);
        lit("add_T4_alu", 32'(alu_at(b + 4)), 32'h03);
        lit("st_T6_read", 32'(has(b2 + 6, READ)), 0);
        lit("st_T7_write", 32'(has(b2 + 7, WRITE)), 1);
        lit("add_T5_write", 32'(has(b + 5, WRITE)), 0);

        b = hist.size();
        run_instr("br_con0", 32'h9A800000, 1'b0, 1'b0, -1);
        b2 = hist.size();
        run_instr("br_con1", 32'h9A800000, 1'b1, 1'b0, -1);
        lit("br0_T6_PCin", 32'(has(b + 6, PCIN)), 0);
        lit("br0_next_T0", 32'(has(b + 7, PCOUT | INCPC)), 1);
        lit("br1_T6_PCin", 32'(has(b2 + 6, PCIN)), 1);

        for (int op = 0; op < 32; op++) begin
            logic [4:0] o;
            o = 5'(op);
            if (o != 5'd27)
                run_instr($sformatf("op%0d", op), {o, 27'h0155},
                          o[1], 1'b0, -1);
        end

        b = hist.size();
        run_instr("mul_stop", 32'h79180000, 1'b0, 1'b1, -1);
        expect_idle(3);
        lit("mul_T6_HIin", 32'(has(b + 6, HIIN)), 1);
        lit("mul_halt_run", 32'(run_at(b + 8)), 0);

        apply_reset(2);
        b = hist.size();
        run_instr("halt", 32'hD8000000, 1'b0, 1'b0, -1);
        expect_idle(3);
        lit("halt_T3_run", 32'(run_at(b + 3)), 1);
        lit("halt_S_run", 32'(run_at(b + 4)), 0);

        apply_reset(2);
        b = hist.size();
        run_instr("ld_abort", 32'h00800075, 1'b0, 1'b0, 4);
        lit("abort_T4_Zin", 32'(has(b + 4, COUT | ZIN)), 1);
        lit("abort_no_MARin", 32'(has(b + 5, MARIN)), 0);
        lit("abort_run", 32'(run_at(b + 5)), 0);

`ifdef MEM_WAIT_EN
        t1_wait = 3;
        b = hist.size();
        run_instr("nop_wait", 32'hD0000000, 1'b0, 1'b0, -1);
        t1_wait = 0;
        for (int k = 1; k <= 4; k++)
            lit($sformatf("wait_T1_%0d", k), 32'(has(b + k, READ | MDRIN)), 1);
        lit("wait_T2", 32'(has(b + 5, MDROUT | IRIN)), 1);
`endif

        run_instr("ld_final", 32'h00800075, 1'b0, 1'b0, -1);
        lit("queue_drained", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
